wishbone_2mst_arbiter: RTL and testbench

- Shares one Wishbone slave bus between two Wishbone masters: the Caravel management bus (m0) and an internal autonomous sequencer (m1).
- Sits upstream of the 1-master-to-4-slave interconnect. Its slave side drives the interconnect's master port.
- Grants ownership per bus cycle (cyc held), using round-robin or fixed priority.
- A per-transfer watchdog terminates hung transfers with an error-pattern ack.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_timeout_watchdog.sv | 38 +++
 rtl/wishbone_2mst_arbiter.sv | 145 ++++++++++++++
 tb/tb_wishbone_2mst_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encodings
// (which double as the one-hot grant), priority-mode names and data defaults.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/wb_timeout_watchdog.sv
// Per-transfer watchdog: counts stalled strobe cycles and flags the cycle
// in which the transfer must be force-terminated. TIMEOUT = 0 disables it.
module wb_timeout_watchdog #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic clear,
  output logic hit
);

  localparam bit EN = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  generate
    if (TIMEOUT < 0 || TIMEOUT >= (1 << TIMEOUT_W)) begin : g_bad_timeout
      $error("wb_timeout_watchdog: TIMEOUT must be below 2**TIMEOUT_W");
    end
  endgenerate

  logic [TIMEOUT_W-1:0] count_q;

  assign hit = EN && active && (count_q == LAST);

  // The hit cycle clears the counter, so it never reaches a wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear || !active || hit || !EN) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/wishbone_2mst_arbiter.sv
// Two-master Wishbone arbiter: per-cycle ownership (round-robin or fixed
// priority), combinational bus mux and a watchdog that aborts hung transfers.
module wishbone_2mst_arbiter
  import wb_arb_pkg::*;
#(
  parameter int          PRIO_MODE = PRIO_RR,
  parameter int          TIMEOUT_W = 8,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_m0_cyc_i,
  input  logic        wbs_m0_stb_i,
  input  logic        wbs_m0_we_i,
  input  logic [31:0] wbs_m0_adr_i,
  input  logic [31:0] wbs_m0_dat_i,
  input  logic [3:0]  wbs_m0_sel_i,
  output logic [31:0] wbs_m0_dat_o,
  output logic        wbs_m0_ack_o,
  input  logic        wbs_m1_cyc_i,
  input  logic        wbs_m1_stb_i,
  input  logic        wbs_m1_we_i,
  input  logic [31:0] wbs_m1_adr_i,
  input  logic [31:0] wbs_m1_dat_i,
  input  logic [3:0]  wbs_m1_sel_i,
  output logic [31:0] wbs_m1_dat_o,
  output logic        wbs_m1_ack_o,
  output logic        wbs_s_cyc_o,
  output logic        wbs_s_stb_o,
  output logic        wbs_s_we_o,
  output logic [31:0] wbs_s_adr_o,
  output logic [31:0] wbs_s_dat_o,
  output logic [3:0]  wbs_s_sel_o,
  input  logic [31:0] wbs_s_dat_i,
  input  logic        wbs_s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  // Handshake: a master owns the bus from grant until it drops cyc; each
  // beat is stb high until ack (slave or watchdog) is returned in that cycle.

  arb_state_t state_q;
  arb_state_t state_d;
  logic       prefer_m1_q;
  logic       owner_stb;
  logic       wd_active;
  logic       wd_clear;
  logic       timeout_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        case ({wbs_m1_cyc_i, wbs_m0_cyc_i})
          2'b01:   state_d = OWN0;
          2'b10:   state_d = OWN1;
          2'b11:   state_d = (PRIO_MODE == PRIO_FIXED || !prefer_m1_q) ? OWN0 : OWN1;
          default: state_d = IDLE;
        endcase
      end
      OWN0: if (!wbs_m0_cyc_i) state_d = wbs_m1_cyc_i ? OWN1 : IDLE;
      OWN1: if (!wbs_m1_cyc_i) state_d = wbs_m0_cyc_i ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer records the master that just released, so a later tie goes
  // to the other one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prefer_m1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == OWN0 && !wbs_m0_cyc_i) prefer_m1_q <= 1'b1;
      if (state_q == OWN1 && !wbs_m1_cyc_i) prefer_m1_q <= 1'b0;
    end
  end

  assign grant_o = state_q;

  always_comb begin
    owner_stb = 1'b0;
    case (state_q)
      OWN0:    owner_stb = wbs_m0_stb_i;
      OWN1:    owner_stb = wbs_m1_stb_i;
      default: owner_stb = 1'b0;
    endcase
  end

  assign wd_active = owner_stb && !wbs_s_ack_i;
  assign wd_clear  = (state_d != state_q);

  wb_timeout_watchdog #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (wd_active),
    .clear  (wd_clear),
    .hit    (timeout_hit)
  );

  assign timeout_o = timeout_hit;

  always_comb begin
    wbs_s_cyc_o  = 1'b0;
    wbs_s_stb_o  = 1'b0;
    wbs_s_we_o   = 1'b0;
    wbs_s_adr_o  = '0;
    wbs_s_dat_o  = '0;
    wbs_s_sel_o  = '0;
    wbs_m0_ack_o = 1'b0;
    wbs_m0_dat_o = '0;
    wbs_m1_ack_o = 1'b0;
    wbs_m1_dat_o = '0;
    case (state_q)
      OWN0: begin
        wbs_s_cyc_o  = wbs_m0_cyc_i;
        wbs_s_stb_o  = wbs_m0_stb_i && !timeout_hit;
        wbs_s_we_o   = wbs_m0_we_i;
        wbs_s_adr_o  = wbs_m0_adr_i;
        wbs_s_dat_o  = wbs_m0_dat_i;
        wbs_s_sel_o  = wbs_m0_sel_i;
        wbs_m0_ack_o = (wbs_s_ack_i && wbs_m0_stb_i) || timeout_hit;
        wbs_m0_dat_o = timeout_hit ? ERR_DATA : wbs_s_dat_i;
      end
      OWN1: begin
        wbs_s_cyc_o  = wbs_m1_cyc_i;
        wbs_s_stb_o  = wbs_m1_stb_i && !timeout_hit;
        wbs_s_we_o   = wbs_m1_we_i;
        wbs_s_adr_o  = wbs_m1_adr_i;
        wbs_s_dat_o  = wbs_m1_dat_i;
        wbs_s_sel_o  = wbs_m1_sel_i;
        wbs_m1_ack_o = (wbs_s_ack_i && wbs_m1_stb_i) || timeout_hit;
        wbs_m1_dat_o = timeout_hit ? ERR_DATA : wbs_s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wishbone_2mst_arbiter.sv
// Directed bench for wishbone_2mst_arbiter: one round-robin and one
// fixed-priority instance share stimulus; table vectors plus corner sequences.
module tb_wishbone_2mst_arbiter;

  localparam logic [31:0] M0_ADR  = 32'h30030004;
  localparam logic [31:0] M0_WDAT = 32'h12345678;
  localparam logic [31:0] M1_ADR  = 32'h30000010;
  localparam logic [31:0] M1_WDAT = 32'h0000C0DE;
  localparam logic [31:0] S_DAT   = 32'hA5A50001;

  logic clk;
  logic rst_n;
  logic m0_cyc, m0_stb, m0_we;
  logic m1_cyc, m1_stb, m1_we;
  logic s_ack;

  logic        s_cyc [2];
  logic        s_stb [2];
  logic        s_we  [2];
  logic [31:0] s_adr [2];
  logic [31:0] s_wdat[2];
  logic [3:0]  s_sel [2];
  logic [31:0] m0_dat[2];
  logic [31:0] m1_dat[2];
  logic        m0_ack[2];
  logic        m1_ack[2];
  logic [1:0]  grant [2];
  logic        tmo   [2];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: round-robin, instance 1: fixed priority; both TIMEOUT = 8.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    wishbone_2mst_arbiter #(.PRIO_MODE(g), .TIMEOUT_W(8), .TIMEOUT(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wbs_m0_cyc_i (m0_cyc),
      .wbs_m0_stb_i (m0_stb),
      .wbs_m0_we_i  (m0_we),
      .wbs_m0_adr_i (M0_ADR),
      .wbs_m0_dat_i (M0_WDAT),
      .wbs_m0_sel_i (4'hF),
      .wbs_m0_dat_o (m0_dat[g]),
      .wbs_m0_ack_o (m0_ack[g]),
      .wbs_m1_cyc_i (m1_cyc),
      .wbs_m1_stb_i (m1_stb),
      .wbs_m1_we_i  (m1_we),
      .wbs_m1_adr_i (M1_ADR),
      .wbs_m1_dat_i (M1_WDAT),
      .wbs_m1_sel_i (4'h3),
      .wbs_m1_dat_o (m1_dat[g]),
      .wbs_m1_ack_o (m1_ack[g]),
      .wbs_s_cyc_o  (s_cyc[g]),
      .wbs_s_stb_o  (s_stb[g]),
      .wbs_s_we_o   (s_we[g]),
      .wbs_s_adr_o  (s_adr[g]),
      .wbs_s_dat_o  (s_wdat[g]),
      .wbs_s_sel_o  (s_sel[g]),
      .wbs_s_dat_i  (S_DAT),
      .wbs_s_ack_i  (s_ack),
      .grant_o      (grant[g]),
      .timeout_o    (tmo[g])
    );
  end

  typedef struct packed {
    logic       fp;
    logic       rst_n;
    logic       c0, s0, c1, s1, ack;
    logic [1:0] g;
    logic       stb, a0, a1;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic fp, r, c0, s0, c1, s1, ack,
                     input logic [1:0] g, input logic stb, a0, a1);
    vec_t v;
    v = '{fp, r, c0, s0, c1, s1, ack, g, stb, a0, a1};
    tbl.push_back(v);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    vec_t v;
    int   d;
    logic [31:0] e_adr, e_wdat, e_d0, e_d1;
    logic [3:0]  e_sel;
    logic        e_cyc, e_we;

    // fp rst c0 s0 c1 s1 ack | grant stb a0 a1 -- rows are single cycles
    add(0,0,0,0,0,0,0,2'b00,0,0,0);
    add(0,1,1,1,0,0,0,2'b00,0,0,0);   // m0 write, slave acks on 3rd owned cycle
    add(0,1,1,1,0,0,0,2'b01,1,0,0);
    add(0,1,1,1,0,0,0,2'b01,1,0,0);
    add(0,1,1,1,0,0,1,2'b01,1,1,0);
    add(0,1,0,0,0,0,0,2'b01,0,0,0);
    add(0,0,0,0,0,0,0,2'b00,0,0,0);   // reset restores m0 preference
    add(0,1,1,1,1,1,0,2'b00,0,0,0);   // tie rounds, direct handoffs
    add(0,1,1,1,1,1,0,2'b01,1,0,0);
    add(0,1,1,1,1,1,1,2'b01,1,1,0);
    add(0,1,0,0,1,1,0,2'b01,0,0,0);
    add(0,1,1,1,1,1,1,2'b10,1,0,1);
    add(0,1,1,1,0,0,0,2'b10,0,0,0);
    add(0,1,1,1,1,1,1,2'b01,1,1,0);
    add(0,1,0,0,1,1,0,2'b01,0,0,0);
    add(0,1,0,0,1,1,1,2'b10,1,0,1);
    add(0,1,0,0,0,0,0,2'b10,0,0,0);
    add(0,1,1,1,1,1,0,2'b00,0,0,0);
    add(0,1,1,1,1,1,1,2'b01,1,1,0);
    add(0,1,0,0,1,1,0,2'b01,0,0,0);
    add(0,1,0,0,1,1,1,2'b10,1,0,1);
    add(0,1,0,0,0,0,0,2'b10,0,0,0);
    add(0,1,0,0,0,0,1,2'b00,0,0,0);   // ack while idle is ignored
    add(0,1,1,1,0,0,0,2'b00,0,0,0);
    add(0,1,1,1,0,0,1,2'b01,1,1,0);
    add(0,1,0,0,0,0,0,2'b01,0,0,0);
    add(0,1,1,1,1,1,0,2'b00,0,0,0);   // tie after m0 release goes to m1
    add(0,1,1,1,1,1,1,2'b10,1,0,1);
    add(0,1,1,1,0,0,0,2'b10,0,0,0);
    add(0,1,1,1,0,0,1,2'b01,1,1,0);
    add(0,1,0,0,0,0,0,2'b01,0,0,0);
    add(0,1,0,0,0,0,0,2'b00,0,0,0);
    add(0,1,0,0,1,1,0,2'b00,0,0,0);   // m1 4-beat burst, m0 waiting
    add(0,1,1,1,1,1,0,2'b10,1,0,0);
    add(0,1,1,1,1,1,1,2'b10,1,0,1);
    add(0,1,1,1,1,0,0,2'b10,0,0,0);
    add(0,1,1,1,1,1,1,2'b10,1,0,1);
    add(0,1,1,1,1,0,0,2'b10,0,0,0);
    add(0,1,1,1,1,1,1,2'b10,1,0,1);
    add(0,1,1,1,1,0,0,2'b10,0,0,0);
    add(0,1,1,1,1,1,1,2'b10,1,0,1);
    add(0,1,1,1,0,0,0,2'b10,0,0,0);
    add(0,1,1,1,0,0,1,2'b01,1,1,0);
    add(0,1,0,0,0,0,0,2'b01,0,0,0);
    add(0,1,0,0,0,0,0,2'b00,0,0,0);
    add(1,0,0,0,0,0,0,2'b00,0,0,0);   // fixed-priority instance
    add(1,1,1,1,0,0,0,2'b00,0,0,0);
    add(1,1,1,1,0,0,1,2'b01,1,1,0);
    add(1,1,0,0,0,0,0,2'b01,0,0,0);
    add(1,1,1,1,1,1,0,2'b00,0,0,0);   // tie after m0 release still m0
    add(1,1,1,1,1,1,1,2'b01,1,1,0);
    add(1,1,0,0,1,1,0,2'b01,0,0,0);
    add(1,1,1,1,1,1,1,2'b10,1,0,1);
    add(1,1,1,1,0,0,0,2'b10,0,0,0);
    add(1,1,1,1,1,1,1,2'b01,1,1,0);
    add(1,1,0,0,1,1,0,2'b01,0,0,0);
    add(1,1,0,0,1,1,1,2'b10,1,0,1);
    add(1,1,0,0,0,0,0,2'b10,0,0,0);
    add(1,1,1,1,1,1,0,2'b00,0,0,0);
    add(1,1,1,1,1,1,1,2'b01,1,1,0);
    add(1,1,0,0,0,0,0,2'b01,0,0,0);
    add(1,1,0,0,0,0,0,2'b00,0,0,0);

    rst_n = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b1;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    s_ack = 1'b0;
    repeat (2) next_cycle();

    foreach (tbl[i]) begin
      v = tbl[i];
      d = v.fp ? 1 : 0;
      rst_n = v.rst_n;
      m0_cyc = v.c0; m0_stb = v.s0;
      m1_cyc = v.c1; m1_stb = v.s1;
      s_ack = v.ack;
      @(negedge clk);
      e_cyc = 1'b0; e_we = 1'b0; e_adr = '0; e_wdat = '0; e_sel = '0; e_d0 = '0; e_d1 = '0;
      if (v.g == 2'b01) begin
        e_cyc = v.c0; e_we = m0_we; e_adr = M0_ADR; e_wdat = M0_WDAT; e_sel = 4'hF; e_d0 = S_DAT;
      end else if (v.g == 2'b10) begin
        e_cyc = v.c1; e_we = m1_we; e_adr = M1_ADR; e_wdat = M1_WDAT; e_sel = 4'h3; e_d1 = S_DAT;
      end
      chk32($sformatf("v%0d_grant", i), {30'd0, grant[d]}, {30'd0, v.g});
      chk1($sformatf("v%0d_s_cyc", i), s_cyc[d], e_cyc);
      chk1($sformatf("v%0d_s_stb", i), s_stb[d], v.stb);
      chk1($sformatf("v%0d_s_we", i), s_we[d], e_we);
      chk32($sformatf("v%0d_s_adr", i), s_adr[d], e_adr);
      chk32($sformatf("v%0d_s_wdat", i), s_wdat[d], e_wdat);
      chk32($sformatf("v%0d_s_sel", i), {28'd0, s_sel[d]}, {28'd0, e_sel});
      chk1($sformatf("v%0d_m0_ack", i), m0_ack[d], v.a0);
      chk1($sformatf("v%0d_m1_ack", i), m1_ack[d], v.a1);
      chk32($sformatf("v%0d_m0_dat", i), m0_dat[d], e_d0);
      chk32($sformatf("v%0d_m1_dat", i), m1_dat[d], e_d1);
      chk1($sformatf("v%0d_timeout", i), tmo[d], 1'b0);
      next_cycle();
    end

    // Unacked m0 read: forced ack 8 cycles after stb; then slave ack landing
    // on the would-be timeout cycle wins.
    for (int mode = 0; mode < 2; mode++) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0;
      for (int k = 0; k <= 8; k++) begin
        s_ack = (mode == 1 && k == 8);
        @(negedge clk);
        chk1($sformatf("to%0d_k%0d_ack", mode, k), m0_ack[0], k == 8);
        chk1($sformatf("to%0d_k%0d_pulse", mode, k), tmo[0], mode == 0 && k == 8);
        chk1($sformatf("to%0d_k%0d_stb", mode, k), s_stb[0], k != 0 && !(mode == 0 && k == 8));
        chk1($sformatf("to%0d_k%0d_m1_ack", mode, k), m1_ack[0], 1'b0);
        if (k == 8)
          chk32($sformatf("to%0d_dat", mode), m0_dat[0], (mode == 0) ? 32'hDEADBEEF : S_DAT);
        next_cycle();
      end
      m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
      @(negedge clk);
      chk1($sformatf("to%0d_after_pulse", mode), tmo[0], 1'b0);
      chk1($sformatf("to%0d_after_ack", mode), m0_ack[0], 1'b0);
      next_cycle();
      @(negedge clk);
      chk32($sformatf("to%0d_idle_grant", mode), {30'd0, grant[0]}, 32'd0);
      next_cycle();
    end
    m0_we = 1'b1;

    // Reset during an m1 transfer whose ack arrives only after the reset edge.
    m1_cyc = 1'b1; m1_stb = 1'b1;
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk32("rst_pre_grant", {30'd0, grant[0]}, 32'd2);
    chk1("rst_pre_ack", m1_ack[0], 1'b0);
    next_cycle();
    rst_n = 1'b1; s_ack = 1'b1;
    @(negedge clk);
    chk32("rst_grant", {30'd0, grant[0]}, 32'd0);
    chk1("rst_late_ack", m1_ack[0], 1'b0);
    chk1("rst_s_cyc", s_cyc[0], 1'b0);
    chk1("rst_s_stb", s_stb[0], 1'b0);
    chk32("rst_s_adr", s_adr[0], 32'd0);
    chk32("rst_m1_dat", m1_dat[0], 32'd0);
    chk1("rst_timeout", tmo[0], 1'b0);
    next_cycle();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    repeat (2) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
